fir_coef_bank_writer: RTL and testbench

Double-buffered coefficient store that drives the `coef` array input of pipelined_fir_filter. The write side (PS register bridge or a preset sequencer) loads a shadow bank one tap at a time through a valid/ready port. A commit swaps the shadow bank to active on a sample_clk edge, so the filter never sees a half-updated set. After each swap the new active bank is copied back into the shadow, so partial edits start from the current coefficients.

---
 rtl/fir_pkg.sv | 17 +
 rtl/fir_coef_ram2.sv | 45 ++++
 rtl/fir_coef_bank_writer.sv | 134 +++++++++++++
 tb/tb_fir_coef_bank_writer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR coefficient path.
package fir_pkg;

    localparam int FIR_NUM_COEF = 24;

    typedef shortint coef_t;
    typedef coef_t   coef_bank_t [FIR_NUM_COEF];

    typedef enum logic {
        READY = 1'b0,
        COPY  = 1'b1
    } coef_wr_state_t;

    // 32767 with the FIR's >>>15 gives near-unity gain on a single tap.
    localparam coef_t COEF_UNITY = 16'sd32767;

endpackage

// File: rtl/fir_coef_ram2.sv
// Two coefficient banks with a two-address write port into one selected bank
// and a full parallel read of the other selected bank.
module fir_coef_ram2
    import fir_pkg::*;
#(
    parameter int NUM_COEF    = FIR_NUM_COEF,
    parameter int ADDR_W      = $clog2(NUM_COEF),
    parameter int DEFAULT_TAP = NUM_COEF/2 - 1
) (
    input  logic              sample_clk,
    input  logic              rst,
    input  logic              i_wbank,
    input  logic              i_we_a,
    input  logic [ADDR_W-1:0] i_addr_a,
    input  coef_t             i_data_a,
    input  logic              i_we_b,
    input  logic [ADDR_W-1:0] i_addr_b,
    input  coef_t             i_data_b,
    input  logic              i_rd_sel,
    output coef_t             o_rd_data [NUM_COEF]
);

    coef_t r_bank0 [NUM_COEF];
    coef_t r_bank1 [NUM_COEF];

    always_ff @(posedge sample_clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_COEF; i++) begin
                r_bank0[i] <= (i == DEFAULT_TAP) ? COEF_UNITY : coef_t'(0);
                r_bank1[i] <= (i == DEFAULT_TAP) ? COEF_UNITY : coef_t'(0);
            end
        end else begin
            if (i_we_a && !i_wbank) r_bank0[i_addr_a] <= i_data_a;
            if (i_we_a &&  i_wbank) r_bank1[i_addr_a] <= i_data_a;
            if (i_we_b && !i_wbank) r_bank0[i_addr_b] <= i_data_b;
            if (i_we_b &&  i_wbank) r_bank1[i_addr_b] <= i_data_b;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_COEF; i++)
            o_rd_data[i] = i_rd_sel ? r_bank1[i] : r_bank0[i];
    end

endmodule

// File: rtl/fir_coef_bank_writer.sv
// Double-buffered FIR coefficient store: writes land in the shadow bank, a commit
// swaps banks, then the new active bank is copied back into the shadow.
// Optional FIR_COEF_SYMMETRIC_EN: lower-half writes are mirrored (linear phase).
module fir_coef_bank_writer
    import fir_pkg::*;
#(
    parameter int NUM_COEF    = FIR_NUM_COEF,
    parameter int ADDR_W      = $clog2(NUM_COEF),
    parameter int DEFAULT_TAP = NUM_COEF/2 - 1
) (
    input  logic              sample_clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  coef_t             wr_data,
    input  logic              commit_valid,
    output logic              commit_ready,
    output coef_t             coef_out [NUM_COEF],
    output logic              bank_sel,
    output logic [7:0]        cfg_gen,
    output logic              addr_err,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_COEF - 1);

    coef_wr_state_t    r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_ci;
    logic              r_bank_sel;
    logic [7:0]        r_cfg_gen;
    logic              r_addr_err;

    logic              w_in_range;
    logic              w_commit_fire;
    logic              w_addr_bad;
    logic              w_we_a, w_we_b;
    logic [ADDR_W-1:0] w_addr_a, w_mirror;
    coef_t             w_data_a;

    assign w_mirror = LAST_IDX - wr_addr;

`ifdef FIR_COEF_SYMMETRIC_EN
    assign w_in_range = int'(wr_addr) < NUM_COEF/2;
`else
    assign w_in_range = int'(wr_addr) < NUM_COEF;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        wr_ready      = 1'b0;
        commit_ready  = 1'b0;
        busy          = 1'b0;
        w_commit_fire = 1'b0;
        w_addr_bad    = 1'b0;
        w_we_a        = 1'b0;
        w_we_b        = 1'b0;
        w_addr_a      = wr_addr;
        w_data_a      = wr_data;
        case (r_state)
            READY: begin
                wr_ready      = 1'b1;
                commit_ready  = 1'b1;
                w_commit_fire = commit_valid;
                if (wr_valid) begin
                    if (w_in_range) begin
                        w_we_a = 1'b1;
`ifdef FIR_COEF_SYMMETRIC_EN
                        w_we_b = 1'b1;
`endif
                    end else begin
                        w_addr_bad = 1'b1;
                    end
                end
                if (commit_valid) w_state_nxt = COPY;
            end
            COPY: begin
                // coef_out already reflects the newly active bank here.
                busy     = 1'b1;
                w_we_a   = 1'b1;
                w_addr_a = r_ci;
                w_data_a = coef_out[r_ci];
                if (r_ci == LAST_IDX) w_state_nxt = READY;
            end
            default: w_state_nxt = READY;
        endcase
    end

    always_ff @(posedge sample_clk) begin
        if (rst) begin
            r_state    <= READY;
            r_ci       <= '0;
            r_bank_sel <= 1'b0;
            r_cfg_gen  <= '0;
            r_addr_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_commit_fire) begin
                r_bank_sel <= ~r_bank_sel;
                r_cfg_gen  <= r_cfg_gen + 8'd1;
                r_ci       <= '0;
            end else if (r_state == COPY) begin
                r_ci <= (r_ci == LAST_IDX) ? '0 : r_ci + 1'b1;
            end
            // A dropped write in the commit cycle still gets reported.
            if (w_addr_bad)         r_addr_err <= 1'b1;
            else if (w_commit_fire) r_addr_err <= 1'b0;
        end
    end

    // Shadow is always the inactive bank, so a same-cycle write joins the swap.
    fir_coef_ram2 #(
        .NUM_COEF    (NUM_COEF),
        .ADDR_W      (ADDR_W),
        .DEFAULT_TAP (DEFAULT_TAP)
    ) u_ram (
        .sample_clk (sample_clk),
        .rst        (rst),
        .i_wbank    (~r_bank_sel),
        .i_we_a     (w_we_a),
        .i_addr_a   (w_addr_a),
        .i_data_a   (w_data_a),
        .i_we_b     (w_we_b),
        .i_addr_b   (w_mirror),
        .i_data_b   (wr_data),
        .i_rd_sel   (r_bank_sel),
        .o_rd_data  (coef_out)
    );

    assign bank_sel = r_bank_sel;
    assign cfg_gen  = r_cfg_gen;
    assign addr_err = r_addr_err;

endmodule

// File: tb/tb_fir_coef_bank_writer.sv
// Directed bench for fir_coef_bank_writer; FIR_COEF_SYMMETRIC_EN selects the
// symmetric-mode expectations.
module tb_fir_coef_bank_writer;

    logic       sample_clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [4:0] wr_addr = '0;
    shortint    wr_data = 0;
    logic       commit_valid = 1'b0;
    logic       commit_ready;
    shortint    coef_out [24];
    logic       bank_sel;
    logic [7:0] cfg_gen;
    logic       addr_err;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    fir_coef_bank_writer dut (
        .sample_clk   (sample_clk),
        .rst          (rst),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .commit_valid (commit_valid),
        .commit_ready (commit_ready),
        .coef_out     (coef_out),
        .bank_sel     (bank_sel),
        .cfg_gen      (cfg_gen),
        .addr_err     (addr_err),
        .busy         (busy)
    );

    always #5 sample_clk = ~sample_clk;

    task automatic tick();
        @(posedge sample_clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!(wr_ready && commit_ready) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            n_err++;
            $display("FAIL wait_ready timeout got busy=%0d want ready", busy);
        end
    endtask

    task automatic do_write(input logic [4:0] a, input shortint d);
        wait_ready();
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic do_commit();
        wait_ready();
        commit_valid = 1'b1;
        tick();
        commit_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 24; i++) begin
            shortint e;
            e = (i == 11) ? 16'sd32767 : 16'sd0;
            n_cmp++;
            if (coef_out[i] !== e) begin
                n_err++;
                $display("FAIL reset_tap%0d got %0d want %0d", i, coef_out[i], e);
            end
        end
        n_cmp++; if (bank_sel !== 1'b0) begin n_err++; $display("FAIL reset_bank_sel got %0d want 0", bank_sel); end
        n_cmp++; if (cfg_gen !== 8'd0) begin n_err++; $display("FAIL reset_cfg_gen got %0d want 0", cfg_gen); end
        n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL reset_wr_ready got %0d want 1", wr_ready); end
        n_cmp++; if (commit_ready !== 1'b1) begin n_err++; $display("FAIL reset_commit_ready got %0d want 1", commit_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0d want 0", busy); end
        n_cmp++; if (addr_err !== 1'b0) begin n_err++; $display("FAIL reset_addr_err got %0d want 0", addr_err); end
    endtask

    task automatic test_shadow_isolation();
        int n = 0;
        do_write(5'd0, -16'sd70);
        do_write(5'd23, -16'sd70);
        n_cmp++; if (coef_out[0] !== 16'sd0) begin n_err++; $display("FAIL iso_pre_tap0 got %0d want 0", coef_out[0]); end
        n_cmp++; if (coef_out[23] !== 16'sd0) begin n_err++; $display("FAIL iso_pre_tap23 got %0d want 0", coef_out[23]); end
        do_commit();
        n_cmp++; if (coef_out[0] !== -16'sd70) begin n_err++; $display("FAIL iso_tap0 got %0d want -70", coef_out[0]); end
        n_cmp++; if (coef_out[23] !== -16'sd70) begin n_err++; $display("FAIL iso_tap23 got %0d want -70", coef_out[23]); end
        n_cmp++; if (coef_out[11] !== 16'sd32767) begin n_err++; $display("FAIL iso_tap11 got %0d want 32767", coef_out[11]); end
        n_cmp++; if (bank_sel !== 1'b1) begin n_err++; $display("FAIL iso_bank_sel got %0d want 1", bank_sel); end
        n_cmp++; if (cfg_gen !== 8'd1) begin n_err++; $display("FAIL iso_cfg_gen got %0d want 1", cfg_gen); end
        while (busy && n < 100) begin
            n++;
            tick();
        end
        n_cmp++; if (n !== 24) begin n_err++; $display("FAIL iso_busy_cycles got %0d want 24", n); end
        n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL iso_ready_after got %0d want 1", wr_ready); end
    endtask

    task automatic test_write_commit_same_cycle();
        wait_ready();
        wr_valid = 1'b1; wr_addr = 5'd5; wr_data = 16'sd1049;
        commit_valid = 1'b1;
        tick();
        wr_valid = 1'b0; commit_valid = 1'b0;
        n_cmp++; if (coef_out[5] !== 16'sd1049) begin n_err++; $display("FAIL simul_tap5 got %0d want 1049", coef_out[5]); end
        n_cmp++; if (coef_out[0] !== -16'sd70) begin n_err++; $display("FAIL simul_tap0 got %0d want -70", coef_out[0]); end
        n_cmp++; if (bank_sel !== 1'b0) begin n_err++; $display("FAIL simul_bank_sel got %0d want 0", bank_sel); end
        n_cmp++; if (cfg_gen !== 8'd2) begin n_err++; $display("FAIL simul_cfg_gen got %0d want 2", cfg_gen); end
    endtask

    task automatic test_copy_blocking();
        int n = 0;
        do_commit();
        wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 16'sd622;
        while (!wr_ready && n < 100) begin
            if (commit_ready !== 1'b0) begin
                n_cmp++; n_err++;
                $display("FAIL block_commit_ready got %0d want 0", commit_ready);
            end
            n++;
            tick();
        end
        n_cmp++; if (n !== 24) begin n_err++; $display("FAIL block_cycles got %0d want 24", n); end
        tick();
        wr_valid = 1'b0;
        n_cmp++; if (coef_out[3] !== 16'sd0) begin n_err++; $display("FAIL block_tap3_pre got %0d want 0", coef_out[3]); end
        do_commit();
        n_cmp++; if (coef_out[3] !== 16'sd622) begin n_err++; $display("FAIL block_tap3 got %0d want 622", coef_out[3]); end
        n_cmp++; if (coef_out[5] !== 16'sd1049) begin n_err++; $display("FAIL block_copyback_tap5 got %0d want 1049", coef_out[5]); end
        n_cmp++; if (cfg_gen !== 8'd4) begin n_err++; $display("FAIL block_cfg_gen got %0d want 4", cfg_gen); end
        n_cmp++; if (bank_sel !== 1'b0) begin n_err++; $display("FAIL block_bank_sel got %0d want 0", bank_sel); end
    endtask

    task automatic test_addr_err();
        do_write(5'd30, 16'sd1234);
        n_cmp++; if (addr_err !== 1'b1) begin n_err++; $display("FAIL aerr_set got %0d want 1", addr_err); end
        n_cmp++; if (coef_out[3] !== 16'sd622) begin n_err++; $display("FAIL aerr_tap3 got %0d want 622", coef_out[3]); end
        do_commit();
        n_cmp++; if (addr_err !== 1'b0) begin n_err++; $display("FAIL aerr_clear got %0d want 0", addr_err); end
        n_cmp++; if (coef_out[6] !== 16'sd0) begin n_err++; $display("FAIL aerr_tap6 got %0d want 0", coef_out[6]); end
        n_cmp++; if (coef_out[3] !== 16'sd622) begin n_err++; $display("FAIL aerr_tap3_post got %0d want 622", coef_out[3]); end
        n_cmp++; if (cfg_gen !== 8'd5) begin n_err++; $display("FAIL aerr_cfg_gen got %0d want 5", cfg_gen); end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        wait_ready();
        commit_valid = 1'b1;
        tick();
        n_cmp++; if (cfg_gen !== 8'd6) begin n_err++; $display("FAIL b2b_first got %0d want 6", cfg_gen); end
        while (cfg_gen == 8'd6 && n < 100) begin
            tick();
            n++;
        end
        commit_valid = 1'b0;
        n_cmp++; if (n !== 25) begin n_err++; $display("FAIL b2b_spacing got %0d want 25", n); end
        n_cmp++; if (cfg_gen !== 8'd7) begin n_err++; $display("FAIL b2b_second got %0d want 7", cfg_gen); end
    endtask

    task automatic test_gen_wrap();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        for (int k = 0; k < 255; k++) do_commit();
        n_cmp++; if (cfg_gen !== 8'd255) begin n_err++; $display("FAIL wrap_255 got %0d want 255", cfg_gen); end
        n_cmp++; if (bank_sel !== 1'b1) begin n_err++; $display("FAIL wrap_bank_255 got %0d want 1", bank_sel); end
        do_commit();
        n_cmp++; if (cfg_gen !== 8'd0) begin n_err++; $display("FAIL wrap_0 got %0d want 0", cfg_gen); end
        n_cmp++; if (bank_sel !== 1'b0) begin n_err++; $display("FAIL wrap_bank got %0d want 0", bank_sel); end
        n_cmp++; if (coef_out[11] !== 16'sd32767) begin n_err++; $display("FAIL wrap_tap11 got %0d want 32767", coef_out[11]); end
    endtask

    task automatic test_symmetric();
        do_write(5'd2, -16'sd42);
        do_commit();
        n_cmp++; if (coef_out[2] !== -16'sd42) begin n_err++; $display("FAIL sym_tap2 got %0d want -42", coef_out[2]); end
`ifdef FIR_COEF_SYMMETRIC_EN
        n_cmp++; if (coef_out[21] !== -16'sd42) begin n_err++; $display("FAIL sym_tap21 got %0d want -42", coef_out[21]); end
        do_write(5'd14, 16'sd77);
        n_cmp++; if (addr_err !== 1'b1) begin n_err++; $display("FAIL sym_upper_err got %0d want 1", addr_err); end
        do_commit();
        n_cmp++; if (coef_out[14] !== 16'sd0) begin n_err++; $display("FAIL sym_tap14 got %0d want 0", coef_out[14]); end
`else
        n_cmp++; if (coef_out[21] !== 16'sd0) begin n_err++; $display("FAIL nosym_tap21 got %0d want 0", coef_out[21]); end
        do_write(5'd14, 16'sd77);
        n_cmp++; if (addr_err !== 1'b0) begin n_err++; $display("FAIL nosym_upper_err got %0d want 0", addr_err); end
        do_commit();
        n_cmp++; if (coef_out[14] !== 16'sd77) begin n_err++; $display("FAIL nosym_tap14 got %0d want 77", coef_out[14]); end
        n_cmp++; if (coef_out[9] !== 16'sd0) begin n_err++; $display("FAIL nosym_tap9 got %0d want 0", coef_out[9]); end
`endif
    endtask

    initial begin
        test_reset();
        test_shadow_isolation();
        test_write_commit_same_cycle();
        test_copy_blocking();
        test_addr_err();
        test_back_to_back();
        test_gen_wrap();
        test_symmetric();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
